rgb_sequencer: RTL and testbench

Sequences the board RGB LED through a fixed eight-step colour pattern, each step held for a programmable number of prescaler ticks. It sits between the top level and the LED pins in place of free-running counter blinking, and adds start/stop/hold control plus busy/done status. Runs once or loops, selected by parameter.

---
 rtl/rgb_sequencer_pkg.sv | 31 +++
 rtl/rgb_sequencer_tick_prescaler.sv | 41 ++++
 rtl/rgb_sequencer.sv | 139 +++++++++++++
 tb/tb_rgb_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_sequencer_pkg.sv
// rgb_seq_pkg: shared types and constants for the RGB LED sequencer.
//   state_t      - sequencer FSM states (IDLE, RUN, HOLD)
//   STEP_COUNT   - number of steps in the colour pattern
//   DUR_W        - width of a step duration, in prescaler ticks
//   COLOR_TABLE  - {r,g,b} colour per step
//   DUR_TABLE    - step duration in ticks (0 is treated as 1)
package rgb_seq_pkg;

   localparam int STEP_COUNT = 8;
   localparam int DUR_W      = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [2:0] COLOR_TABLE [STEP_COUNT] = '{
      3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111, 3'b000
   };

   localparam logic [DUR_W-1:0] DUR_TABLE [STEP_COUNT] = '{
      4'd4, 4'd4, 4'd4, 4'd2, 4'd2, 4'd2, 4'd8, 4'd8
   };

   // A zero-length step would never terminate, so it is stretched to one tick.
   function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] dur);
      return (dur == '0) ? DUR_W'(1) : dur;
   endfunction

endpackage

// File: rtl/rgb_sequencer_tick_prescaler.sv
// tick_prescaler: free-running p_tick_bit-wide counter producing a one-cycle
// tick every 2^p_tick_bit enabled clocks.
//   i_clk   - clock
//   i_rst   - synchronous active-high reset (counter to 0)
//   i_clr   - synchronous clear (counter to 0), wins over i_en
//   i_en    - count enable; counter frozen while low
//   o_tick  - high for the cycle in which the counter is all-ones and enabled;
//             the counter wraps to 0 on that same edge
module tick_prescaler #(
   parameter int p_tick_bit = 22
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tick
);

   logic [p_tick_bit-1:0] cnt_q;
   logic [p_tick_bit-1:0] cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      o_tick = 1'b0;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d  = cnt_q + p_tick_bit'(1);
         o_tick = &cnt_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rgb_sequencer.sv
// rgb_sequencer: drives the board RGB LED through an eight-step colour
// pattern, each step held for a table-defined number of prescaler ticks.
//   p_tick_bit          - tick period is 2^p_tick_bit clocks (1..30)
//   p_loop              - 1: wrap step 7 -> 0 forever; 0: run once then idle
//   i_clk, i_rst        - clock, synchronous active-high reset
//   i_start             - one-cycle start request, ignored while busy
//   i_stop              - abort to idle, LEDs off, no done pulse
//   i_hold              - level; freezes the sequence on the current colour
//   o_led_r/g/b         - registered LED drives, 1 = on
//   o_busy              - high in RUN and HOLD
//   o_step              - current step index
//   o_done              - one-cycle pulse when a run-once sequence ends
module rgb_sequencer
   import rgb_seq_pkg::*;
#(
   parameter int p_tick_bit = 22,
   parameter int p_loop     = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   input  logic       i_stop,
   input  logic       i_hold,
   output logic       o_led_r,
   output logic       o_led_g,
   output logic       o_led_b,
   output logic       o_busy,
   output logic [2:0] o_step,
   output logic       o_done
);

   state_t            state_q, state_d;
   logic [2:0]        step_q, step_d;
   logic [DUR_W-1:0]  tick_cnt_q, tick_cnt_d;
   logic [2:0]        led_q, led_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [DUR_W-1:0]  last_tick;
   logic              tick;

   // Prescaler only runs in RUN, so HOLD freezes it; it sits cleared in IDLE
   // so every start begins a full tick period.
   tick_prescaler #(
      .p_tick_bit (p_tick_bit)
   ) u_presc (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (state_q == S_IDLE),
      .i_en   (state_q == S_RUN),
      .o_tick (tick)
   );

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      tick_cnt_d = tick_cnt_q;
      done_d     = 1'b0;
      last_tick  = eff_dur(DUR_TABLE[step_q]) - DUR_W'(1);

      unique case (state_q)
         S_IDLE: begin
            if (i_start && !i_stop) begin
               state_d    = S_RUN;
               step_d     = 3'd0;
               tick_cnt_d = '0;
            end
         end
         S_RUN: begin
            if (i_stop) begin
               state_d    = S_IDLE;
               step_d     = 3'd0;
               tick_cnt_d = '0;
            end else if (i_hold) begin
               // A tick arriving with hold entry is dropped on purpose.
               state_d = S_HOLD;
            end else if (tick) begin
               if (tick_cnt_q == last_tick) begin
                  tick_cnt_d = '0;
                  if (step_q == 3'(STEP_COUNT - 1)) begin
                     step_d = 3'd0;
                     if (p_loop == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end
                  end else begin
                     step_d = step_q + 3'd1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + DUR_W'(1);
               end
            end
         end
         S_HOLD: begin
            if (i_stop) begin
               state_d    = S_IDLE;
               step_d     = 3'd0;
               tick_cnt_d = '0;
            end else if (!i_hold) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d    = S_IDLE;
            step_d     = 3'd0;
            tick_cnt_d = '0;
         end
      endcase

      // Outputs are derived from the next state so they register alongside it.
      busy_d = (state_d != S_IDLE);
      led_d  = busy_d ? COLOR_TABLE[step_d] : 3'b000;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= S_IDLE;
         step_q     <= 3'd0;
         tick_cnt_q <= '0;
         led_q      <= 3'b000;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         tick_cnt_q <= tick_cnt_d;
         led_q      <= led_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign o_led_r = led_q[2];
   assign o_led_g = led_q[1];
   assign o_led_b = led_q[0];
   assign o_busy  = busy_q;
   assign o_step  = step_q;
   assign o_done  = done_q;

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer. Expected output changes (cycle stamp,
// busy, step, leds, done) are queued when stimulus is issued; monitors pop and
// compare whenever a DUT output vector changes.
module tb_rgb_sequencer;
   import rgb_seq_pkg::*;

   typedef struct {
      int         cyc;
      logic       busy;
      logic [2:0] step;
      logic [2:0] led;
      logic       done;
   } exp_t;

   localparam int DUR_CLK [8] = '{16, 16, 16, 8, 8, 8, 32, 32};
   localparam logic [2:0] COL [8] = '{3'b100, 3'b010, 3'b001, 3'b110,
                                      3'b011, 3'b101, 3'b111, 3'b000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_o = 1'b1, rst_x = 1'b1;
   logic start_o = 1'b0, stop_o = 1'b0, hold_o = 1'b0;
   logic start_l = 1'b0, start_g = 1'b0;

   logic       r_o, g_o, b_o, busy_o, done_o;
   logic [2:0] step_o;
   logic       r_l, g_l, b_l, busy_l, done_l;
   logic [2:0] step_l;
   logic       r_g, g_g, b_g, busy_g, done_g;
   logic [2:0] step_g;

   rgb_sequencer #(.p_tick_bit(2), .p_loop(0)) u_once (
      .i_clk(clk), .i_rst(rst_o), .i_start(start_o), .i_stop(stop_o), .i_hold(hold_o),
      .o_led_r(r_o), .o_led_g(g_o), .o_led_b(b_o),
      .o_busy(busy_o), .o_step(step_o), .o_done(done_o)
   );

   rgb_sequencer #(.p_tick_bit(2), .p_loop(1)) u_loop (
      .i_clk(clk), .i_rst(rst_x), .i_start(start_l), .i_stop(1'b0), .i_hold(1'b0),
      .o_led_r(r_l), .o_led_g(g_l), .o_led_b(b_l),
      .o_busy(busy_l), .o_step(step_l), .o_done(done_l)
   );

   rgb_sequencer #(.p_tick_bit(22), .p_loop(1)) u_long (
      .i_clk(clk), .i_rst(rst_x), .i_start(start_g), .i_stop(1'b0), .i_hold(1'b0),
      .o_led_r(r_g), .o_led_g(g_g), .o_led_b(b_g),
      .o_busy(busy_g), .o_step(step_g), .o_done(done_g)
   );

   exp_t q_once[$];
   exp_t q_loop[$];
   int   checks = 0;
   int   errors = 0;
   logic mon_on = 1'b0;
   logic [7:0] prev_o = 8'h00;
   logic [7:0] prev_l = 8'h00;

   task automatic push_o(input int c, input logic b, input logic [2:0] s,
                         input logic [2:0] l, input logic d);
      exp_t e;
      e.cyc = c; e.busy = b; e.step = s; e.led = l; e.done = d;
      q_once.push_back(e);
   endtask

   task automatic push_l(input int c, input logic b, input logic [2:0] s,
                         input logic [2:0] l, input logic d);
      exp_t e;
      e.cyc = c; e.busy = b; e.step = s; e.led = l; e.done = d;
      q_loop.push_back(e);
   endtask

   // Full run-once sequence starting on edge s.
   task automatic push_full_run(input int s);
      int t;
      t = s;
      for (int k = 0; k < 8; k++) begin
         push_o(t, 1'b1, 3'(k), COL[k], 1'b0);
         t += DUR_CLK[k];
      end
      push_o(t, 1'b0, 3'd0, 3'b000, 1'b1);
      push_o(t + 1, 1'b0, 3'd0, 3'b000, 1'b0);
   endtask

   task automatic wait_cyc(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, req);
      end else begin
         $display("check %s cyc=%0d value=%0h ok", name, cyc, got);
      end
   endtask

   // Monitor for the run-once instance.
   always @(negedge clk) begin : mon_once
      logic [7:0] cur, req;
      exp_t e;
      if (mon_on) begin
         cur = {busy_o, step_o, r_o, g_o, b_o, done_o};
         if (cur !== prev_o) begin
            checks++;
            if (q_once.size() == 0) begin
               errors++;
               $display("FAIL once_unexpected cyc=%0d got=%b required=no change", cyc, cur);
            end else begin
               e   = q_once.pop_front();
               req = {e.busy, e.step, e.led, e.done};
               if (cur !== req || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL once_event cyc=%0d got=%b required=%b at cyc %0d",
                           cyc, cur, req, e.cyc);
               end else begin
                  $display("once cyc=%0d busy=%b step=%0d led=%b done=%b ok",
                           cyc, cur[7], cur[6:4], cur[3:1], cur[0]);
               end
            end
            prev_o = cur;
         end
      end
   end

   // Monitor for the looping instance, over the first 310 cycles.
   always @(negedge clk) begin : mon_loop
      logic [7:0] cur, req;
      exp_t e;
      if (mon_on && cyc <= 310) begin
         cur = {busy_l, step_l, r_l, g_l, b_l, done_l};
         if (cur !== prev_l) begin
            checks++;
            if (q_loop.size() == 0) begin
               errors++;
               $display("FAIL loop_unexpected cyc=%0d got=%b required=no change", cyc, cur);
            end else begin
               e   = q_loop.pop_front();
               req = {e.busy, e.step, e.led, e.done};
               if (cur !== req || cyc != e.cyc) begin
                  errors++;
                  $display("FAIL loop_event cyc=%0d got=%b required=%b at cyc %0d",
                           cyc, cur, req, e.cyc);
               end else begin
                  $display("loop cyc=%0d busy=%b step=%0d led=%b done=%b ok",
                           cyc, cur[7], cur[6:4], cur[3:1], cur[0]);
               end
            end
            prev_l = cur;
         end
      end
   end

   initial begin
      int t;
      // Reset state
      wait_cyc(4);
      check("reset_once_outs", {24'd0, busy_o, step_o, r_o, g_o, b_o, done_o}, 32'd0);
      check("reset_once_state", 32'(u_once.state_q), 32'(S_IDLE));
      check("reset_loop_outs", {24'd0, busy_l, step_l, r_l, g_l, b_l, done_l}, 32'd0);
      rst_o = 1'b0; rst_x = 1'b0; mon_on = 1'b1;

      // Run-once, looping and long-run instances all start on edge 10
      push_full_run(10);
      push_l(10, 1'b1, 3'd0, 3'b100, 1'b0);
      t = 10;
      for (int n = 1; n < 40; n++) begin
         t += DUR_CLK[(n - 1) % 8];
         if (t <= 310) push_l(t, 1'b1, 3'(n % 8), COL[n % 8], 1'b0);
      end
      wait_cyc(9);  start_o = 1'b1; start_l = 1'b1; start_g = 1'b1;
      wait_cyc(10); start_o = 1'b0; start_l = 1'b0; start_g = 1'b0;

      // Hold away from a tick during step 1: step 1 lasts 36 clocks
      push_o(200, 1'b1, 3'd0, 3'b100, 1'b0);
      push_o(216, 1'b1, 3'd1, 3'b010, 1'b0);
      push_o(252, 1'b1, 3'd2, 3'b001, 1'b0);
      push_o(268, 1'b1, 3'd3, 3'b110, 1'b0);
      push_o(272, 1'b0, 3'd0, 3'b000, 1'b0);
      wait_cyc(199); start_o = 1'b1;
      wait_cyc(200); start_o = 1'b0;
      wait_cyc(217); hold_o = 1'b1;
      wait_cyc(230);
      check("hold_led", {29'd0, r_o, g_o, b_o}, 32'b010);
      check("hold_state", 32'(u_once.state_q), 32'(S_HOLD));
      wait_cyc(237); hold_o = 1'b0;
      // Stop during step 3
      wait_cyc(271); stop_o = 1'b1;
      wait_cyc(272); stop_o = 1'b0;

      // Hold entered on a tick edge: tick dropped, step 1 lasts 40 clocks;
      // start while busy ignored; stop in step 2
      push_o(300, 1'b1, 3'd0, 3'b100, 1'b0);
      push_o(316, 1'b1, 3'd1, 3'b010, 1'b0);
      push_o(356, 1'b1, 3'd2, 3'b001, 1'b0);
      push_o(362, 1'b0, 3'd0, 3'b000, 1'b0);
      wait_cyc(299); start_o = 1'b1;
      wait_cyc(300); start_o = 1'b0;
      wait_cyc(311);
      check("loop_busy", {31'd0, busy_l}, 32'd1);
      wait_cyc(319); hold_o = 1'b1;
      wait_cyc(339); hold_o = 1'b0;
      wait_cyc(359); start_o = 1'b1;
      wait_cyc(360); start_o = 1'b0;
      wait_cyc(361); stop_o = 1'b1;
      wait_cyc(362); stop_o = 1'b0;

      // Start together with stop in IDLE: stays idle
      wait_cyc(399); start_o = 1'b1; stop_o = 1'b1;
      wait_cyc(400); start_o = 1'b0; stop_o = 1'b0;
      wait_cyc(402);
      check("start_stop_busy", {31'd0, busy_o}, 32'd0);
      check("start_stop_state", 32'(u_once.state_q), 32'(S_IDLE));

      // Reset mid-run for 5 cycles, then a normal start
      push_o(450, 1'b1, 3'd0, 3'b100, 1'b0);
      push_o(466, 1'b1, 3'd1, 3'b010, 1'b0);
      push_o(470, 1'b0, 3'd0, 3'b000, 1'b0);
      wait_cyc(449); start_o = 1'b1;
      wait_cyc(450); start_o = 1'b0;
      wait_cyc(469); rst_o = 1'b1;
      wait_cyc(472);
      check("midrun_reset_outs", {24'd0, busy_o, step_o, r_o, g_o, b_o, done_o}, 32'd0);
      check("midrun_reset_state", 32'(u_once.state_q), 32'(S_IDLE));
      wait_cyc(474); rst_o = 1'b0;
      push_o(480, 1'b1, 3'd0, 3'b100, 1'b0);
      push_o(496, 1'b1, 3'd1, 3'b010, 1'b0);
      push_o(500, 1'b0, 3'd0, 3'b000, 1'b0);
      wait_cyc(479); start_o = 1'b1;
      wait_cyc(480); start_o = 1'b0;
      wait_cyc(499); stop_o = 1'b1;
      wait_cyc(500); stop_o = 1'b0;

      // Long run with a 2^22 tick period: never leaves step 0
      wait_cyc(40000);
      check("long_step", {29'd0, step_g}, 32'd0);
      check("long_led", {29'd0, r_g, g_g, b_g}, 32'b100);
      check("long_busy", {31'd0, busy_g}, 32'd1);
      check("long_presc_nonzero", {31'd0, (u_long.u_presc.cnt_q != '0)}, 32'd1);
      check("long_no_x", {31'd0, $isunknown({busy_g, step_g, r_g, g_g, b_g, done_g})}, 32'd0);

      // Every queued event must have been seen
      checks++;
      if (q_once.size() != 0 || q_loop.size() != 0) begin
         errors++;
         $display("FAIL missing_events got=%0d/%0d pending required=0/0",
                  q_once.size(), q_loop.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
